// File: rtl/inv_port_arbiter.sv
// Three-requester inventory port arbiter: purchase, restock and display read share one inventory port.
// Define INV_ARB_RR_EN for round-robin arbitration; otherwise fixed priority req[0] > req[1] > req[2].
module inv_port_arbiter #(
  parameter int STOCK_MAX = 5,
  parameter int DW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [1:0]    req_item0,
  input  logic [1:0]    req_item1,
  input  logic [1:0]    req_item2,
  output logic [2:0]    gnt,
  output logic          done,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          inv_rd_en,
  output logic          inv_wr_en,
  output logic [1:0]    inv_item,
  output logic [DW-1:0] inv_wdata,
  input  logic [DW-1:0] inv_rdata
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate among active requests
  // RD     | inventory read strobe for the latched item
  // CAP    | capture read data, compute write data
  // WR     | inventory write strobe
  // DONE   | completion pulse, grant still held
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  localparam logic [DW-1:0] STOCK_MAX_W = DW'(STOCK_MAX);
  localparam logic [DW-1:0] ONE_W       = DW'(1);

  state_t        state, state_nxt;
  logic [1:0]    win_nxt, win_q;
  logic          win_vld;
  logic [1:0]    sel_item, item_q;
  logic [DW-1:0] wdata_nxt, wdata_q;
  logic          cap_write;

`ifdef INV_ARB_RR_EN
  logic [1:0] ptr_q;

  // Search order rotates so the requester after the last winner goes first.
  always_comb begin
    win_vld = |req;
    win_nxt = 2'd0;
    case (ptr_q)
      2'd1:    win_nxt = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    win_nxt = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_nxt = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= 2'd0;
    else if (state == S_DONE)
      ptr_q <= (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
  end
`else
  always_comb begin
    win_vld = |req;
    win_nxt = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  always_comb begin
    case (win_nxt)
      2'd1:    sel_item = req_item1;
      2'd2:    sel_item = req_item2;
      default: sel_item = req_item0;
    endcase
  end

  // Decrement saturates at zero and clamps oversized stock to STOCK_MAX.
  always_comb begin
    wdata_nxt = '0;
    cap_write = 1'b0;
    case (win_q)
      2'd0: begin
        if (inv_rdata != '0) begin
          cap_write = 1'b1;
          wdata_nxt = (inv_rdata > STOCK_MAX_W) ? STOCK_MAX_W : inv_rdata - ONE_W;
        end
      end
      2'd1: begin
        cap_write = 1'b1;
        wdata_nxt = STOCK_MAX_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_RD;
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = cap_write ? S_WR : S_DONE;
      S_WR:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 3'b000;
      win_q    <= 2'd0;
      item_q   <= 2'd0;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            win_q   <= win_nxt;
            gnt     <= 3'b001 << win_nxt;
            item_q  <= sel_item;
            rsp_err <= 1'b0;
          end
        end
        S_CAP: begin
          rsp_data <= inv_rdata;
          wdata_q  <= wdata_nxt;
          rsp_err  <= (win_q == 2'd0) && (inv_rdata == '0);
        end
        S_DONE:  gnt <= 3'b000;
        default: ;
      endcase
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  always_comb begin
    done      = (state == S_DONE);
    inv_rd_en = (state == S_RD);
    inv_wr_en = (state == S_WR);
    inv_item  = ((state == S_RD) || (state == S_WR)) ? item_q : 2'd0;
    inv_wdata = (state == S_WR) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_inv_port_arbiter.sv
// Directed bench for inv_port_arbiter: vector table of single transactions plus
// contention, reset-during-write and early-drop sequences.
module tb_inv_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [1:0] req_item0, req_item1, req_item2;
  logic [2:0] gnt;
  logic       done;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       inv_rd_en, inv_wr_en;
  logic [1:0] inv_item;
  logic [3:0] inv_wdata;
  logic [3:0] inv_rdata;

  int checks = 0;
  int errors = 0;

  inv_port_arbiter #(.STOCK_MAX(5), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_item0(req_item0), .req_item1(req_item1), .req_item2(req_item2),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inv_rd_en(inv_rd_en), .inv_wr_en(inv_wr_en), .inv_item(inv_item),
    .inv_wdata(inv_wdata), .inv_rdata(inv_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [1:0] item;
    logic [3:0] rdata;
    logic [2:0] gnt;
    bit         wr;
    logic [3:0] wdata;
    logic [3:0] rsp;
    bit         err;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         wr_cyc, done_cyc;
    logic [3:0] wd, rd;
    logic       er;
    logic [2:0] g;
    wr_cyc = 0; done_cyc = 0; wd = '0; rd = '0; er = 1'b0; g = '0;
    @(negedge clk);
    req       = v.req;
    req_item0 = v.req[0] ? v.item : ~v.item;
    req_item1 = v.req[1] ? v.item : ~v.item;
    req_item2 = v.req[2] ? v.item : ~v.item;
    inv_rdata = v.rdata;
    for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("rd_en_n1", int'(inv_rd_en), 1);
        chk("gnt_rd", int'(gnt), int'(v.gnt));
        chk("rd_item", int'(inv_item), int'(v.item));
        chk("err_clr", int'(rsp_err), 0);
      end
      chk("rd_wr_excl", int'(inv_rd_en & inv_wr_en), 0);
      if (inv_wr_en) begin
        wr_cyc = c;
        wd = inv_wdata;
        chk("wr_item", int'(inv_item), int'(v.item));
      end
      if (done) begin
        done_cyc = c; rd = rsp_data; er = rsp_err; g = gnt;
      end
    end
    req = 3'b000;
    chk("done_lat", done_cyc, v.lat);
    chk("wr_cycle", wr_cyc, v.wr ? 3 : 0);
    if (v.wr) chk("wdata", int'(wd), int'(v.wdata));
    chk("rsp_data", int'(rd), int'(v.rsp));
    chk("rsp_err", int'(er), int'(v.err));
    chk("gnt_done", int'(g), int'(v.gnt));
    @(negedge clk);
    chk("gnt_clear", int'(gnt), 0);
    chk("done_single", int'(done), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g[4];
    int         found;

    //            req     item rdata gnt    wr    wdata rsp   err  lat
    vecs[0] = '{3'b001, 2'd0, 4'd4,  3'b001, 1'b1, 4'd3, 4'd4,  1'b0, 4};
    vecs[1] = '{3'b001, 2'd1, 4'd0,  3'b001, 1'b0, 4'd0, 4'd0,  1'b1, 3};
    vecs[2] = '{3'b010, 2'd2, 4'd2,  3'b010, 1'b1, 4'd5, 4'd2,  1'b0, 4};
    vecs[3] = '{3'b100, 2'd3, 4'd7,  3'b100, 1'b0, 4'd0, 4'd7,  1'b0, 3};
    vecs[4] = '{3'b001, 2'd2, 4'd15, 3'b001, 1'b1, 4'd5, 4'd15, 1'b0, 4};
    vecs[5] = '{3'b001, 2'd3, 4'd1,  3'b001, 1'b1, 4'd0, 4'd1,  1'b0, 4};
    vecs[6] = '{3'b010, 2'd1, 4'd0,  3'b010, 1'b1, 4'd5, 4'd0,  1'b0, 4};

    rst_n = 1'b0; req = 3'b000; inv_rdata = 4'd0;
    req_item0 = 2'd0; req_item1 = 2'd0; req_item2 = 2'd0;
    #12;
    chk("reset_outputs", int'({gnt, done, rsp_data, rsp_err, inv_rd_en, inv_wr_en, inv_item, inv_wdata}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_quiet", int'({gnt, inv_rd_en, done}), 0);
    end

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Contention with all requests held.
`ifdef INV_ARB_RR_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
    do_reset();
    req_item0 = 2'd0; req_item1 = 2'd0; req_item2 = 2'd0;
    inv_rdata = 4'd3;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int c = 0; c < 8 && found == 0; c++) begin
        @(negedge clk);
        if (done) begin
          found = 1;
          chk("contention_gnt", int'(gnt), int'(exp_g[k]));
        end
      end
      if (found == 0) chk("contention_done", 0, 1);
    end
    req = 3'b000;
    @(negedge clk);
    @(negedge clk);

    // Reset asserted while the write strobe is up.
    req = 3'b001; req_item0 = 2'd1; inv_rdata = 4'd4;
    found = 0;
    for (int c = 0; c < 8 && found == 0; c++) begin
      @(negedge clk);
      if (inv_wr_en) found = 1;
    end
    chk("wr_reached", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_in_wr", int'({gnt, done, rsp_data, rsp_err, inv_rd_en, inv_wr_en, inv_item, inv_wdata}), 0);
    req = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_idle", int'({gnt, done, inv_rd_en, inv_wr_en}), 0);
    end

    // Display read whose request drops during CAP.
    req = 3'b100; req_item2 = 2'd1; req_item0 = 2'd2; req_item1 = 2'd3; inv_rdata = 4'd6;
    @(negedge clk);
    chk("drop_rd", int'({inv_rd_en, inv_item}), int'({1'b1, 2'd1}));
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    chk("drop_done", int'(done), 1);
    chk("drop_gnt_held", int'(gnt), 4);
    chk("drop_rsp", int'(rsp_data), 6);
    @(negedge clk);
    chk("drop_gnt_clear", int'({gnt, done}), 0);
    @(negedge clk);
    chk("drop_no_restart", int'(inv_rd_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_port_arbiter.md
INV_PORT_ARBITER -- requirements
Module: inv_port_arbiter

Interface
REQ-001 Parameter STOCK_MAX, default 5, stock value written by a restock operation.
REQ-002 Parameter DW, default 4, stock word width.
REQ-003 The block SHALL have these ports: clk, input, 1 bit, system clock, all logic on the rising edge.
REQ-004 The block SHALL have these ports: rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have these ports: req, input, 3 bits, level requests; [0] purchase (decrement), [1] restock, [2] display read.
REQ-006 The block SHALL have these ports: req_item0, req_item1 and req_item2, input, 2 bits each, item index for each requester.
REQ-007 The block SHALL have these ports: gnt, output, 3 bits, one-hot grant.
REQ-008 The block SHALL have these ports: done, output, 1 bit, single-cycle completion pulse for the granted requester.
REQ-009 The block SHALL have these ports: rsp_data, output, DW bits, stock value read in the transaction.
REQ-010 The block SHALL have these ports: rsp_err, output, 1 bit, set when a decrement finds stock 0.
REQ-011 The block SHALL have these ports: inv_rd_en, inv_wr_en, output, 1 bit each, inventory read strobe and write strobe.
REQ-012 The block SHALL have these ports: inv_item, output, 2 bits, inventory address.
REQ-013 The block SHALL have these ports: inv_wdata, output, DW bits, inventory write data.
REQ-014 The block SHALL have these ports: inv_rdata, input, DW bits, inventory read data, valid the cycle after inv_rd_en.

Function
REQ-015 The FSM SHALL use five states: IDLE, RD, CAP, WR and DONE.
REQ-016 IDLE with any req bit high SHALL select a winner, register gnt one-hot, latch the winner's item and opcode, and go to RD.
REQ-017 IDLE with no req bit high SHALL stay in IDLE with gnt at 0.
REQ-018 RD SHALL drive inv_rd_en=1 and inv_item=latched item for exactly 1 cycle, then go to CAP.
REQ-019 CAP SHALL register inv_rdata into rsp_data and compute write data.
REQ-020 For a decrement in CAP: if stock >0, wdata = stock-1 and go to WR; if stock =0, set rsp_err=1, skip WR and go to DONE.
REQ-021 For a restock in CAP: wdata = STOCK_MAX and go to WR.
REQ-022 For a read in CAP: no write, go to DONE.
REQ-023 WR SHALL drive inv_wr_en=1, inv_item and inv_wdata for exactly 1 cycle, then go to DONE.
REQ-024 DONE SHALL pulse done=1 for 1 cycle with gnt still held, then go to IDLE and clear gnt.
REQ-025 gnt SHALL be stable from RD through DONE, and rsp_data and rsp_err SHALL be valid in the DONE cycle.
REQ-026 rsp_err SHALL clear at the next IDLE->RD transition.
REQ-027 Latency from a request sampled in IDLE at cycle N: done at N+4 for decrement or restock, at N+3 for a read or a decrement at zero.
REQ-028 Requests SHALL be sampled only in IDLE, and a req deasserted mid-transaction SHALL NOT abort it (done still pulses).
REQ-029 A requester SHALL hold req until done; a req still high after done is a new request arbitrated in the next IDLE.
REQ-030 Decrement SHALL never wrap below 0, and the write value SHALL never exceed STOCK_MAX.
REQ-031 inv_rd_en and inv_wr_en SHALL never be high in the same cycle.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear gnt, done, rsp_data, rsp_err, inv_rd_en, inv_wr_en, inv_item and inv_wdata, and set the round-robin pointer to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction without a write strobe, and no done pulse SHALL follow.

Configuration
REQ-034 With INV_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer, and after DONE the pointer = winner+1 mod 3.
REQ-035 Without INV_ARB_RR_EN, arbitration SHALL be fixed priority with req[0] > req[1] > req[2], and no pointer register SHALL exist.

Verification
REQ-036 Decrement: stock 4, req=001, item0 -> inv_rd_en at N+1, inv_wr_en with wdata 3 at N+3, done at N+4 with rsp_data 4 and rsp_err 0.
REQ-037 Decrement at zero: inv_rdata 0 -> no inv_wr_en, done at N+3 with rsp_err 1.
REQ-038 Restock: stock 2, req=010 -> write 5, done with rsp_data 2.
REQ-039 Contention: req=111 held; round-robin build grants 0,1,2,0; fixed build grants 0 repeatedly.
REQ-040 Reset in WR: rst_n low during WR -> all outputs 0 at once, no done pulse, IDLE after release.
REQ-041 Early drop: req[2] dropped in CAP -> done still pulses at N+3, and gnt clears the following cycle.
